mips_divider: RTL and testbench

Multi-cycle integer divider for the MIPS datapath, executing DIV and DIVU. It produces the quotient and remainder that the core writes to LO and HI. It is the subtractive counterpart to the core's combinational adder and reuses it as the trial subtractor. Restoring algorithm, one quotient bit per cycle, with a start/busy/done handshake toward the multi-cycle control unit.

---
 rtl/mips_pkg.sv | 8 +
 rtl/mips_divider_adder.sv | 18 +
 rtl/mips_divider.sv | 124 ++++++++++++
 tb/tb_mips_divider.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: divider FSM states and the divider latency
// used by the multi-cycle control unit for stall timing.
package mips_pkg;
  localparam int DIV_N       = 32;
  localparam int DIV_LATENCY = DIV_N + 2;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
endpackage

// File: rtl/mips_divider_adder.sv
// Core ripple adder, instantiated N+1 wide by the divider as its trial subtractor.
module adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         zero_o,
  output logic         ovf_o,
  output logic         neg_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign zero_o = (sum_o == '0);
  assign neg_o  = sum_o[W-1];
  assign ovf_o  = (a_i[W-1] == b_i[W-1]) && (sum_o[W-1] != a_i[W-1]);
endmodule

// File: rtl/mips_divider.sv
// Restoring DIV/DIVU unit, one quotient bit per cycle, fixed N+2 latency.
// MIPS_DIV_SIGNED_EN compiles in the signed (DIV) path; otherwise all divides are unsigned.
module mips_divider
  import mips_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N);

  div_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q, dsr_q, dvd_q;
  logic          sgn_q_q, sgn_r_q, dz_pend_q;
  logic          busy_q, done_q, dz_q;
  logic [N-1:0]  quotient_q, remainder_q;

  logic [N:0]    rem_sh, trial;
  logic          no_borrow;
  logic          neg_a, neg_b;
  logic [N-1:0]  mag_a, mag_b, q_fix, r_fix;
  logic          unused_zero, unused_ovf, unused_neg, unused_rem_msb;

  // Trial subtract: rem - {0, divisor} as rem + ~{0, divisor} + 1; carry out = no borrow.
  assign rem_sh = {rem_q[N-1:0], quo_q[N-1]};
  assign unused_rem_msb = rem_q[N];

  adder #(.W(N+1)) u_sub (
    .a_i    (rem_sh),
    .b_i    (~{1'b0, dsr_q}),
    .cin_i  (1'b1),
    .sum_o  (trial),
    .cout_o (no_borrow),
    .zero_o (unused_zero),
    .ovf_o  (unused_ovf),
    .neg_o  (unused_neg)
  );

`ifdef MIPS_DIV_SIGNED_EN
  assign neg_a = is_signed & dividend[N-1];
  assign neg_b = is_signed & divisor[N-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;
  assign q_fix = sgn_q_q ? -quo_q : quo_q;
  assign r_fix = sgn_r_q ? -rem_q[N-1:0] : rem_q[N-1:0];
`else
  logic unused_sign;
  assign unused_sign = is_signed ^ sgn_q_q ^ sgn_r_q;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
  assign mag_a = dividend;
  assign mag_b = divisor;
  assign q_fix = quo_q;
  assign r_fix = rem_q[N-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sgn_q_q   <= neg_a ^ neg_b;
            sgn_r_q   <= neg_a;
            rem_q     <= '0;
            quo_q     <= mag_a;
            dsr_q     <= mag_b;
            dvd_q     <= dividend;
            dz_pend_q <= (divisor == '0);
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ITER;
          end
        end
        ITER: begin
          rem_q <= no_borrow ? trial : rem_sh;
          quo_q <= {quo_q[N-2:0], no_borrow};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N-1)) state_q <= FIX;
        end
        // Zero divisor overrides whatever the datapath produced.
        FIX: begin
          quotient_q  <= dz_pend_q ? '1    : q_fix;
          remainder_q <= dz_pend_q ? dvd_q : r_fix;
          dz_q        <= dz_pend_q;
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_mips_divider.sv
// Scoreboard bench for mips_divider: directed and random divides against an arithmetic model.
module tb_mips_divider;
  localparam int N   = 32;
  localparam int LAT = N + 2;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;

  mips_divider #(.N(N)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, input int c);
    exp_t   e;
    longint sa, sb, lq, lr;
    logic   sm;
`ifdef MIPS_DIV_SIGNED_EN
    sm = s;
`else
    sm = s & 1'b0;
`endif
    e.cyc = c;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      e.q = lq[31:0]; e.r = lr[31:0]; e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no result (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
        chk("busy_at_done", {31'b0, busy}, 32'd1);
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
    chk({tag, "_dz"}, {31'b0, div_by_zero}, 32'd0);
  endtask

  // pulse_at / reset_at count negedges after the accepting edge; 0 disables.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input int pulse_at, input int reset_at);
    int k;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    exp_q.push_back(model(a, b, s, cyc));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    k = 1;
    while (!done && k < 100) begin
      if (k == pulse_at) start = 1'b1;
      if (k == pulse_at + 1) start = 1'b0;
      if (k == reset_at) begin
        resetn = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        exp_q.delete();
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done at %0d", k, LAT);
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    resetn = 1'b1;

    issue(32'd100, 32'd7, 1'b0, 0, 0);
    issue(32'hFFFF_FFF9, 32'h2, 1'b1, 0, 0);
    issue(32'd5, 32'd0, 1'b0, 0, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    issue(32'hFFFF_FFFF, 32'h1, 1'b0, 0, 0);
    issue(32'h0, 32'hFFFF_FFFF, 1'b1, 0, 0);
    issue(32'h8000_0000, 32'h0, 1'b1, 0, 0);
    issue(32'h1234_5678, 32'd9, 1'b0, 10, 0);
    issue(32'hDEAD_BEEF, 32'd3, 1'b0, 0, 20);
    issue(32'd77, 32'd5, 1'b1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 300);
        2:       b = -$urandom_range(1, 300);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, 0, 0);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
